// File: rtl/acc_job_ctrl.sv
// rtl/acc_job_ctrl.sv - job sequencer that configures ACC and gates its input stream
module acc_job_ctrl #(
  parameter int LOG_MAX_ITERS          = 16,
  parameter int LOG_MAX_READS_PER_ITER = 12,
  parameter int LOG_MAX_JOBS           = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              job_valid,
  output logic                              job_ready,
  input  logic [LOG_MAX_ITERS-1:0]          job_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0] job_reads,
  output logic                              acc_configure,
  output logic [LOG_MAX_ITERS-1:0]          acc_num_iters,
  output logic [LOG_MAX_READS_PER_ITER-1:0] acc_num_reads,
  input  logic                              up_valid,
  output logic                              up_avail,
  output logic                              acc_valid_in,
  input  logic                              acc_avail_out,
  input  logic                              acc_valid_out,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output logic [LOG_MAX_JOBS-1:0]           jobs_done
);

  localparam int LI = LOG_MAX_ITERS;
  localparam int LR = LOG_MAX_READS_PER_ITER;
  localparam int PW = LI + LR;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CONFIG = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    RETIRE = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     in_rem, in_rem_nxt;
  logic [LR-1:0]     out_rem, out_rem_nxt;
  logic              err_q, err_nxt;
  logic [LI-1:0]     iters_nxt;
  logic [LR-1:0]     reads_nxt;
  logic [LOG_MAX_JOBS-1:0] jobs_done_nxt;
  logic [PW-1:0]     job_words;
  logic              desc_bad;
  logic              monitor_on;

  // Total input words for the presented descriptor, kept at full product width.
  assign job_words = PW'(job_iters) * PW'(job_reads);
  assign desc_bad  = (job_iters == '0) || (job_reads == '0);
  assign monitor_on = (state == RUN) || (state == DRAIN);

  // Next-state, counter updates and all control outputs.
  always_comb begin
    state_nxt     = state;
    in_rem_nxt    = in_rem;
    out_rem_nxt   = out_rem;
    err_nxt       = err_q;
    iters_nxt     = acc_num_iters;
    reads_nxt     = acc_num_reads;
    jobs_done_nxt = jobs_done;
    job_ready     = 1'b0;
    acc_configure = 1'b0;
    up_avail      = 1'b0;
    acc_valid_in  = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    err           = 1'b0;

    case (state)
      IDLE: begin
        busy      = 1'b0;
        job_ready = 1'b1;
        err_nxt   = 1'b0;
        if (job_valid) begin
          iters_nxt   = job_iters;
          reads_nxt   = job_reads;
          in_rem_nxt  = job_words;
          out_rem_nxt = job_reads;
          if (desc_bad) begin
            err_nxt   = 1'b1;
            state_nxt = RETIRE;
          end else begin
            state_nxt = CONFIG;
          end
        end
      end
      CONFIG: begin
        acc_configure = 1'b1;
        state_nxt     = RUN;
      end
      RUN: begin
        up_avail     = acc_avail_out && (in_rem != '0);
        acc_valid_in = up_valid && up_avail;
        if (acc_valid_in) begin
          in_rem_nxt = in_rem - PW'(1);
          if (in_rem == PW'(1)) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        state_nxt = DRAIN;
      end
      RETIRE: begin
        done      = 1'b1;
        err       = err_q;
        state_nxt = IDLE;
        if (!err_q) begin
          jobs_done_nxt = jobs_done + LOG_MAX_JOBS'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Output words retire the job; this wins over the RUN->DRAIN move when both land together.
    if (monitor_on && acc_valid_out && (out_rem != '0)) begin
      out_rem_nxt = out_rem - LR'(1);
      if (out_rem == LR'(1)) begin
        state_nxt = RETIRE;
      end
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      in_rem        <= '0;
      out_rem       <= '0;
      err_q         <= 1'b0;
      acc_num_iters <= '0;
      acc_num_reads <= '0;
      jobs_done     <= '0;
    end else begin
      state         <= state_nxt;
      in_rem        <= in_rem_nxt;
      out_rem       <= out_rem_nxt;
      err_q         <= err_nxt;
      acc_num_iters <= iters_nxt;
      acc_num_reads <= reads_nxt;
      jobs_done     <= jobs_done_nxt;
    end
  end

endmodule

// File: tb/tb_acc_job_ctrl.sv
// tb/tb_acc_job_ctrl.sv - table and scoreboard driven bench for acc_job_ctrl
module tb_acc_job_ctrl;

  localparam int LI = 16;
  localparam int LR = 12;
  localparam int LJ = 16;
  localparam int BUDGET = 6000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [LI-1:0] job_iters = '0;
  logic [LR-1:0] job_reads = '0;
  logic          acc_configure;
  logic [LI-1:0] acc_num_iters;
  logic [LR-1:0] acc_num_reads;
  logic          up_valid = 1'b0;
  logic          up_avail;
  logic          acc_valid_in;
  logic          acc_avail_out = 1'b0;
  logic          acc_valid_out = 1'b0;
  logic          busy;
  logic          done;
  logic          err;
  logic [LJ-1:0] jobs_done;

  always #5 clk = ~clk;

  acc_job_ctrl #(
    .LOG_MAX_ITERS(LI),
    .LOG_MAX_READS_PER_ITER(LR),
    .LOG_MAX_JOBS(LJ)
  ) dut (
    .clk(clk),
    .rst(rst),
    .job_valid(job_valid),
    .job_ready(job_ready),
    .job_iters(job_iters),
    .job_reads(job_reads),
    .acc_configure(acc_configure),
    .acc_num_iters(acc_num_iters),
    .acc_num_reads(acc_num_reads),
    .up_valid(up_valid),
    .up_avail(up_avail),
    .acc_valid_in(acc_valid_in),
    .acc_avail_out(acc_avail_out),
    .acc_valid_out(acc_valid_out),
    .busy(busy),
    .done(done),
    .err(err),
    .jobs_done(jobs_done)
  );

  typedef struct {
    int iters;
    int reads;
    bit bp;
    int extra;
    bit early;
    bit exp_err;
    int exp_xfers;
  } vec_t;

  typedef struct {
    bit err;
    int xfers;
    int cfgs;
    int jd;
  } exp_t;

  vec_t pend[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   model_jd = 0;

  task automatic chk(input string nm, input longint act, input longint exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_job_ready"}, job_ready, 1);
    chk({tag, "_acc_configure"}, acc_configure, 0);
    chk({tag, "_acc_num_iters"}, acc_num_iters, 0);
    chk({tag, "_acc_num_reads"}, acc_num_reads, 0);
    chk({tag, "_up_avail"}, up_avail, 0);
    chk({tag, "_acc_valid_in"}, acc_valid_in, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_jobs_done"}, jobs_done, 0);
  endtask

  // Presents every queued descriptor (held valid back to back), models ACC, scores each retirement.
  task automatic run_pending();
    int   cyc, xfers, total, cur_reads, cur_iters, outs_seen, outs_left;
    int   acc_cyc, last_out, cfgs, jd_due, last_done;
    bit   active, cur_err, cur_bp, cur_early, chk_next, drv_out, exp_up, exp_done;
    vec_t v;
    exp_t e;
    cyc = 0; xfers = 0; total = 0; cur_reads = 0; cur_iters = 0; outs_seen = 0; outs_left = 0;
    acc_cyc = 0; last_out = -10; cfgs = 0; jd_due = 0; last_done = -1;
    active = 1'b0; cur_err = 1'b0; cur_bp = 1'b0; cur_early = 1'b0; chk_next = 1'b0;
    while ((pend.size() > 0 || active || outs_left > 0 || chk_next) && cyc < BUDGET) begin
      if (pend.size() > 0) begin
        job_valid = 1'b1;
        job_iters = LI'(pend[0].iters);
        job_reads = LR'(pend[0].reads);
      end else begin
        job_valid = 1'b0;
        job_iters = '0;
        job_reads = '0;
      end
      acc_avail_out = cur_bp ? ((cyc % 2) == 1) : 1'b1;
      up_valid      = cur_bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      drv_out = (outs_left > 0) &&
                (!active || (!cur_err && cyc >= acc_cyc + 2 && xfers >= total - (cur_early ? 1 : 0)));
      acc_valid_out = drv_out;
      #1;
      exp_up   = active && !cur_err && cyc >= acc_cyc + 2 && xfers < total &&
                 outs_seen < cur_reads && acc_avail_out;
      exp_done = active && ((cur_err && cyc == acc_cyc + 1) ||
                            (!cur_err && outs_seen == cur_reads && cyc == last_out + 1));
      chk("up_avail", up_avail, exp_up);
      chk("acc_valid_in", acc_valid_in, exp_up && up_valid);
      chk("acc_configure", acc_configure, active && !cur_err && cyc == acc_cyc + 1);
      chk("busy", busy, active && cyc > acc_cyc);
      chk("job_ready", job_ready, !(active && cyc > acc_cyc));
      chk("done", done, exp_done);
      if (chk_next) begin
        chk("jobs_done", jobs_done, jd_due);
        chk_next = 1'b0;
      end
      if (active && !cur_err && cyc == acc_cyc + 1) begin
        chk("acc_num_iters", acc_num_iters, cur_iters);
        chk("acc_num_reads", acc_num_reads, cur_reads);
      end
      if (acc_valid_in) xfers++;
      if (acc_configure) cfgs++;
      if (drv_out) begin
        outs_left--;
        if (active && !cur_err && cyc >= acc_cyc + 2 && outs_seen < cur_reads) begin
          outs_seen++;
          last_out = cyc;
        end
      end
      if (done) begin
        chk("sb_size", sb.size(), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("err", err, e.err);
          chk("xfers", xfers, e.xfers);
          chk("cfgs", cfgs, e.cfgs);
          jd_due   = e.jd;
          chk_next = 1'b1;
        end
        active    = 1'b0;
        last_done = (pend.size() > 0) ? cyc : -1;
      end
      if (job_valid && job_ready) begin
        if (last_done >= 0) chk("accept_gap", cyc - last_done, 1);
        v = pend.pop_front();
        cur_iters = v.iters; cur_reads = v.reads; cur_bp = v.bp; cur_early = v.early;
        cur_err = v.exp_err; total = v.exp_xfers;
        acc_cyc = cyc; active = 1'b1; xfers = 0; cfgs = 0; outs_seen = 0; last_out = -10;
        if (!v.exp_err) begin
          outs_left += v.reads + v.extra;
          model_jd++;
        end
        e.err   = v.exp_err;
        e.xfers = v.exp_xfers;
        e.cfgs  = v.exp_err ? 0 : 1;
        e.jd    = model_jd % (1 << LJ);
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("run_finished", active || pend.size() > 0 || chk_next, 0);
    job_valid = 1'b0;
    up_valid = 1'b0;
    acc_avail_out = 1'b0;
    acc_valid_out = 1'b0;
  endtask

  vec_t tbl[8];
  int   n;

  initial begin
    tbl[0] = '{3,  4,  1'b0, 0, 1'b0, 1'b0, 12};
    tbl[1] = '{3,  4,  1'b1, 0, 1'b0, 1'b0, 12};
    tbl[2] = '{0,  5,  1'b0, 0, 1'b0, 1'b1, 0};
    tbl[3] = '{2,  0,  1'b0, 0, 1'b0, 1'b1, 0};
    tbl[4] = '{1,  1,  1'b0, 3, 1'b0, 1'b0, 1};
    tbl[5] = '{2,  1,  1'b0, 0, 1'b1, 1'b0, 2};
    tbl[6] = '{1,  7,  1'b1, 0, 1'b0, 1'b0, 7};
    tbl[7] = '{70, 70, 1'b0, 0, 1'b0, 1'b0, 4900};

    rst = 1'b0;
    up_valid = 1'b1;
    acc_avail_out = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b1;
    up_valid = 1'b0;
    acc_avail_out = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      pend.push_back(tbl[i]);
      run_pending();
    end

    // Second descriptor held valid while the first is in flight.
    pend.push_back('{1, 1, 1'b0, 0, 1'b0, 1'b0, 1});
    pend.push_back('{2, 2, 1'b0, 0, 1'b0, 1'b0, 4});
    run_pending();

    // Output valid while idle must be ignored.
    acc_valid_out = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_jobs_done", jobs_done, model_jd % (1 << LJ));
      @(posedge clk);
      #1;
    end
    acc_valid_out = 1'b0;

    // Reset in the middle of RUN after five transfers.
    job_iters = 16'd3;
    job_reads = 12'd4;
    job_valid = 1'b1;
    up_valid = 1'b1;
    acc_avail_out = 1'b1;
    n = 0;
    for (int c = 0; c < 50 && n < 5; c++) begin
      #1;
      if (acc_valid_in) n++;
      @(posedge clk);
      #1;
      job_valid = 1'b0;
    end
    chk("xfers_before_reset", n, 5);
    chk("busy_before_reset", busy, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_vals("midreset");
    rst = 1'b1;
    up_valid = 1'b0;
    acc_avail_out = 1'b0;
    model_jd = 0;
    @(posedge clk);
    #1;
    pend.push_back('{1, 2, 1'b0, 0, 1'b0, 1'b0, 2});
    run_pending();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
